// File: rtl/prbs_ber_ctrl_pkg.sv
// Shared definitions for the PRBS9 bit-error-rate controller.
// Covers the polynomial tap, the default seed and the FSM state encoding.
package prbs_ber_ctrl_pkg;

    localparam int PRBS_N = 9;
    localparam int FB_TAP = 5;
    localparam logic [PRBS_N-1:0] DEFAULT_SEED = 9'h1AA;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_CHECK   = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    // x^9 + x^5 + 1 in right-shift form taps reg[4] and reg[0]
    function automatic logic prbs9_fb(input logic [PRBS_N-1:0] s);
        return s[PRBS_N-FB_TAP] ^ s[0];
    endfunction

endpackage

// File: rtl/prbs_ber_ctrl_if.sv
// Control, bit-serial loopback and result signals of the BER controller.
// The master side drives the i_* signals and observes the o_* signals.
interface prbs_ber_ctrl_if #(parameter int CNT_W = 32);

    logic             i_start;
    logic             i_abort;
    logic [CNT_W-1:0] i_num_bits;
    logic             i_tx_ready;
    logic             i_rx_bit;
    logic             i_rx_valid;
    logic             o_tx_bit;
    logic             o_tx_valid;
    logic             o_lock;
    logic             o_busy;
    logic             o_done;
    logic [CNT_W-1:0] o_bit_cnt;
    logic [CNT_W-1:0] o_err_cnt;
    logic [7:0]       o_relock_cnt;

    modport master (
        output i_start, i_abort, i_num_bits, i_tx_ready, i_rx_bit, i_rx_valid,
        input  o_tx_bit, o_tx_valid, o_lock, o_busy, o_done,
               o_bit_cnt, o_err_cnt, o_relock_cnt
    );

    modport slave (
        input  i_start, i_abort, i_num_bits, i_tx_ready, i_rx_bit, i_rx_valid,
        output o_tx_bit, o_tx_valid, o_lock, o_busy, o_done,
               o_bit_cnt, o_err_cnt, o_relock_cnt
    );

endinterface

// File: rtl/prbs_ber_ctrl_lfsr.sv
// Right-shift Fibonacci LFSR generator; the output bit is reg[0].
// i_load reloads SEED and takes priority over i_en.
module prbs_ber_ctrl_lfsr
    import prbs_ber_ctrl_pkg::*;
#(
    parameter int               PRBSn = PRBS_N,
    parameter int               TAP   = FB_TAP,
    parameter logic [PRBSn-1:0] SEED  = DEFAULT_SEED
) (
    input  logic i_clk,
    input  logic i_load,
    input  logic i_en,
    output logic o_bit
);

    logic [PRBSn-1:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (i_load) begin
            lfsr_d = SEED;
        end else if (i_en) begin
            lfsr_d = {lfsr_q[PRBSn-TAP] ^ lfsr_q[0], lfsr_q[PRBSn-1:1]};
        end
    end

    always_ff @(posedge i_clk) begin
        lfsr_q <= lfsr_d;
    end

    assign o_bit = lfsr_q[0];

endmodule

// File: rtl/prbs_ber_ctrl.sv
// PRBS9 BER controller: paces/reseeds the TX generator, self-synchronises the
// RX checker and counts checked bits, errors and lock losses per run.
module prbs_ber_ctrl
    import prbs_ber_ctrl_pkg::*;
#(
    parameter int               PRBSn    = PRBS_N,
    parameter logic [PRBSn-1:0] SEED     = DEFAULT_SEED,
    parameter int               CNT_W    = 32,
    parameter int               LOCK_WIN = 64,
    parameter int               LOSS_THR = 8
) (
    input  logic            i_clk,
    input  logic            i_reset,
    prbs_ber_ctrl_if.slave  bus
);

    localparam int BLK_W  = $clog2(LOCK_WIN + 1);
    localparam int BERR_W = $clog2(LOSS_THR + 1);
    localparam int ACQ_W  = $clog2(PRBSn + 1);

    state_e            state_q, state_d;
    logic [PRBSn-1:0]  chk_q, chk_d;
    logic [ACQ_W-1:0]  acq_cnt_q, acq_cnt_d;
    logic [BLK_W-1:0]  blk_cnt_q, blk_cnt_d, blk_cnt_inc;
    logic [BERR_W-1:0] blk_err_q, blk_err_d, blk_err_inc;
    logic [CNT_W-1:0]  num_bits_q, num_bits_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic [7:0]        relock_cnt_q, relock_cnt_d;
    logic              gen_rst_q, gen_rst_d;
    logic              busy, exp_bit, rx_err, gen_bit;

    always_comb begin
        state_d      = state_q;
        chk_d        = chk_q;
        acq_cnt_d    = acq_cnt_q;
        blk_cnt_d    = blk_cnt_q;
        blk_err_d    = blk_err_q;
        num_bits_d   = num_bits_q;
        bit_cnt_d    = bit_cnt_q;
        err_cnt_d    = err_cnt_q;
        relock_cnt_d = relock_cnt_q;
        gen_rst_d    = 1'b0;
        exp_bit      = chk_q[PRBSn-FB_TAP] ^ chk_q[0];
        rx_err       = bus.i_rx_bit ^ exp_bit;
        blk_cnt_inc  = blk_cnt_q + 1'b1;
        blk_err_inc  = blk_err_q + BERR_W'(rx_err);

        if (bus.i_abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.i_start) begin
                        state_d      = ST_ACQUIRE;
                        chk_d        = '0;
                        acq_cnt_d    = '0;
                        blk_cnt_d    = '0;
                        blk_err_d    = '0;
                        num_bits_d   = bus.i_num_bits;
                        bit_cnt_d    = '0;
                        err_cnt_d    = '0;
                        relock_cnt_d = '0;
                        gen_rst_d    = 1'b1;
                    end
                end
                ST_ACQUIRE: begin
                    if (bus.i_rx_valid) begin
                        chk_d     = {bus.i_rx_bit, chk_q[PRBSn-1:1]};
                        acq_cnt_d = acq_cnt_q + 1'b1;
                        if (acq_cnt_q == ACQ_W'(PRBSn - 1)) begin
                            acq_cnt_d = '0;
                            state_d   = (num_bits_q == '0) ? ST_DONE : ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    if (bus.i_rx_valid) begin
                        // Shift in the predicted bit so a line error cannot corrupt the checker
                        chk_d     = {exp_bit, chk_q[PRBSn-1:1]};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        blk_cnt_d = blk_cnt_inc;
                        blk_err_d = blk_err_inc;
                        if (rx_err && (err_cnt_q != '1)) begin
                            err_cnt_d = err_cnt_q + 1'b1;
                        end
                        if (bit_cnt_d == num_bits_q) begin
                            state_d = ST_DONE;
                        end else if (blk_err_inc == BERR_W'(LOSS_THR)) begin
                            state_d   = ST_ACQUIRE;
                            acq_cnt_d = '0;
                            blk_cnt_d = '0;
                            blk_err_d = '0;
                            if (relock_cnt_q != 8'hFF) begin
                                relock_cnt_d = relock_cnt_q + 1'b1;
                            end
                        end else if (blk_cnt_inc == BLK_W'(LOCK_WIN)) begin
                            blk_cnt_d = '0;
                            blk_err_d = '0;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= ST_IDLE;
            chk_q        <= '0;
            acq_cnt_q    <= '0;
            blk_cnt_q    <= '0;
            blk_err_q    <= '0;
            num_bits_q   <= '0;
            bit_cnt_q    <= '0;
            err_cnt_q    <= '0;
            relock_cnt_q <= '0;
            gen_rst_q    <= 1'b1;
        end else begin
            state_q      <= state_d;
            chk_q        <= chk_d;
            acq_cnt_q    <= acq_cnt_d;
            blk_cnt_q    <= blk_cnt_d;
            blk_err_q    <= blk_err_d;
            num_bits_q   <= num_bits_d;
            bit_cnt_q    <= bit_cnt_d;
            err_cnt_q    <= err_cnt_d;
            relock_cnt_q <= relock_cnt_d;
            gen_rst_q    <= gen_rst_d;
        end
    end

    // i_reset also loads the seed directly so o_tx_bit is defined right after reset
    prbs_ber_ctrl_lfsr #(
        .PRBSn (PRBSn),
        .TAP   (FB_TAP),
        .SEED  (SEED)
    ) u_gen (
        .i_clk  (i_clk),
        .i_load (i_reset | gen_rst_q),
        .i_en   (busy & bus.i_tx_ready & ~gen_rst_q),
        .o_bit  (gen_bit)
    );

    assign busy             = (state_q == ST_ACQUIRE) || (state_q == ST_CHECK);
    assign bus.o_busy       = busy;
    assign bus.o_done       = (state_q == ST_DONE);
    assign bus.o_lock       = (state_q == ST_CHECK);
    assign bus.o_tx_valid   = busy & ~gen_rst_q;
    assign bus.o_tx_bit     = gen_bit;
    assign bus.o_bit_cnt    = bit_cnt_q;
    assign bus.o_err_cnt    = err_cnt_q;
    assign bus.o_relock_cnt = relock_cnt_q;

endmodule

// File: doc/prbs_ber_ctrl.md
Name: prbs_ber_ctrl

Overview:
Bit-error-rate test controller built around the team's PRBS9 generator (x^9+x^5+1, right-shift, feedback = reg[4]^reg[0], output reg[0]). It reseeds and paces the local generator on the TX side. On the RX side it self-synchronises a checker to the incoming stream, counts checked bits and bit errors over a programmable run length, and detects loss of lock. It sits between the TX/RX bit-serial loopback and the result registers.

Parameters:
PRBSn, 9, generator/checker state width
SEED, 9'h1AA, generator reseed value loaded on every accepted start
CNT_W, 32, width of bit and error counters
LOCK_WIN, 64, checked-bit block size for lock-loss evaluation
LOSS_THR, 8, errors within one LOCK_WIN block that declare lock lost

Ports:
i_clk  in  1  clock
i_reset  in  1  reset: one clock; reset is synchronous and active-high
i_start  in  1  start pulse; honoured only in IDLE or DONE
i_abort  in  1  abort run, return to IDLE
i_num_bits  in  CNT_W  bits to check per run; sampled at start
i_tx_ready  in  1  downstream accepts a TX bit this cycle
i_rx_bit  in  1  received bit
i_rx_valid  in  1  i_rx_bit qualifier
o_tx_bit  out  1  generator output bit
o_tx_valid  out  1  TX bit valid
o_lock  out  1  checker locked (CHECK state)
o_busy  out  1  run in progress
o_done  out  1  run complete; held until next start, abort or reset
o_bit_cnt  out  CNT_W  bits checked in this run
o_err_cnt  out  CNT_W  errors counted in this run (saturating)
o_relock_cnt  out  8  lock losses in this run (saturating at 255)

Behaviour:
- Reset (i_reset high at clock edge): state IDLE; all outputs 0; counters 0; checker state 0; generator reloaded with SEED via a registered reset pulse (gen_rst = i_reset or start-accept, one cycle).
- FSM states: IDLE, ACQUIRE, CHECK, DONE.
- IDLE/DONE + i_start: next cycle ACQUIRE, o_busy=1, o_done=0, counters cleared, i_num_bits latched, generator reseeded to SEED. i_start in ACQUIRE/CHECK is ignored.
- TX: generator enable = o_busy & i_tx_ready & ~gen_rst. o_tx_valid = o_busy & ~gen_rst. o_tx_bit = generator reg[0]; it advances only when o_tx_valid & i_tx_ready. First 9 bits after start: 0,1,0,1,0,1,0,1,1.
- ACQUIRE: on each i_rx_valid, chk <= {i_rx_bit, chk[8:1]}, acq_cnt++. After the 9th valid bit, go to CHECK; o_lock=1 from that cycle. If latched num_bits==0, go to DONE instead.
- CHECK: exp = chk[4]^chk[0]. On i_rx_valid:
  - chk <= {exp, chk[8:1]}. The checker uses exp, not rx, so a single error does not propagate.
  - bit_cnt++.
  - if i_rx_bit != exp, err_cnt++ (saturates at all-ones) and blk_err++.
  - blk_cnt++.
- Block rollover: when blk_cnt reaches LOCK_WIN, reset blk_cnt and blk_err.
- Lock loss: if blk_err reaches LOSS_THR inside a block, next state ACQUIRE, o_lock=0, relock_cnt++, acq_cnt/blk counters cleared. bit_cnt/err_cnt keep counting across relock.
- Run completion: when bit_cnt reaches num_bits on a valid bit, go to DONE (that bit's error counted). Then o_busy=0, o_done=1, o_lock=0, TX stops. Counters hold.
- Simultaneous events: last bit also triggering loss → DONE wins. i_abort has priority over everything except reset: next state IDLE, o_busy/o_done/o_lock=0, counters hold their values for readout.
- No RX activity: FSM waits indefinitely (no timeout).

Decomposition:
- Shared package: PRBS9 tap constants (FB_TAP=5), default SEED, FSM state encoding (2-bit enum IDLE=0, ACQUIRE=1, CHECK=2, DONE=3).
- One sub-module: instance of the team's existing lfsr generator (PRBSn=9, SEED) for TX. The checker state register and FSM stay inline.

Test Plan:
- Loopback rx=tx (1-cycle delay), num_bits=1000, tx_ready=1 → o_done; bit_cnt=1000, err_cnt=0, relock_cnt=0; first TX bits 0,1,0,1,0,1,0,1,1.
- Same run, flip bit #500 of the checked stream → err_cnt=1, o_lock stays 1, relock_cnt=0.
- Flip 8 consecutive checked bits at #200 → o_lock drops, ACQUIRE for 9 valid bits, relock; relock_cnt=1, err_cnt=8, bit_cnt=1000 at done.
- tx_ready toggled 50%, rx_valid tracking tx → sequence unchanged; err_cnt=0, done after 1000 checked bits.
- i_abort at bit 300 → IDLE next cycle, o_busy=0, o_done=0, bit_cnt=300 held. Repeat with i_reset mid-run → all outputs 0.
- i_start during CHECK ignored; num_bits=0 → DONE right after 9-bit acquire with bit_cnt=0.
